cfifo: RTL

Parametrised multi-port FIFO with write-port compaction, occupancy reporting, and overflow/ordering error flags. It accepts up to WRITE entries and returns up to READ entries per cycle, with first-word-fall-through reads. It replaces the fixed-behaviour multi-port `fifo` in instruction/issue queues, where producers present sparse enables and consumers need occupancy and almost-full back-pressure.

---
 rtl/cfifo.sv | 139 +++++++++++++
 1 files changed

// File: rtl/cfifo.sv
// Multi-port FIFO with write compaction, first-word-fall-through reads,
// occupancy/almost-full reporting and registered drop/ordering error pulses.
module cfifo #(
  parameter int DATA  = 32,
  parameter int DEPTH = 16,
  parameter int READ  = 4,
  parameter int WRITE = 4,
  parameter bit ACT   = 1'b1,
  parameter int AF_TH = DEPTH - WRITE,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset_,
  input  logic                  flush_,
  input  logic [WRITE-1:0]      we,
  input  logic [WRITE*DATA-1:0] wd,
  input  logic [READ-1:0]       re,
  output logic [READ*DATA-1:0]  rd,
  output logic [READ-1:0]       v,
  output logic                  busy,
  output logic                  afull,
  output logic [CW-1:0]         cnt,
  output logic                  wdrop,
  output logic                  rerr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] WRITE_C = CW'(WRITE);
  localparam logic [CW-1:0] AFTH_C  = CW'(AF_TH);

  logic [DATA-1:0] r_data [DEPTH];
  logic [AW-1:0]   r_head;
  logic [AW-1:0]   r_tail;
  logic [CW-1:0]   r_cnt;
  logic            r_wdrop;
  logic            r_rerr;

  logic [WRITE-1:0] w_we;
  logic [READ-1:0]  w_re;
  logic [CW-1:0]    w_nr;
  logic [CW-1:0]    w_nw;
  logic [CW-1:0]    w_free;
  logic             w_live;
  logic             w_rerr;
  logic             w_drop;
  logic [WRITE-1:0] w_wr;
  logic [AW-1:0]    w_slot [WRITE];

  assign w_we = (ACT == 1'b1) ? we : ~we;
  assign w_re = (ACT == 1'b1) ? re : ~re;

  // Outputs are decoded from registered state only.
  always_comb begin
    for (int i = 0; i < READ; i++) begin
      v[i]                = (CW'(i) < r_cnt);
      rd[i*DATA +: DATA]  = r_data[r_head + AW'(i)];
    end
    busy  = ((DEPTH_C - r_cnt) < WRITE_C);
    afull = (r_cnt >= AFTH_C);
    cnt   = r_cnt;
    wdrop = r_wdrop;
    rerr  = r_rerr;
  end

  // Read count is the valid, enabled prefix; any enable past it is an ordering error.
  always_comb begin
    w_nr   = '0;
    w_live = 1'b1;
    w_rerr = 1'b0;
    for (int i = 0; i < READ; i++) begin
      if (w_live && w_re[i] && v[i]) begin
        w_nr = w_nr + ONE_C;
      end else begin
        w_live = 1'b0;
        if (w_re[i]) begin
          w_rerr = 1'b1;
        end else begin
          w_rerr = w_rerr;
        end
      end
    end
  end

  // Pack enabled write ports into consecutive slots, bounded by read-before-write space.
  always_comb begin
    w_free = DEPTH_C - r_cnt + w_nr;
    w_nw   = '0;
    w_drop = 1'b0;
    w_wr   = '0;
    for (int i = 0; i < WRITE; i++) begin
      w_slot[i] = r_tail;
      if (w_we[i]) begin
        if (w_nw < w_free) begin
          w_slot[i] = r_tail + w_nw[AW-1:0];
          w_wr[i]   = 1'b1;
          w_nw      = w_nw + ONE_C;
        end else begin
          w_drop = 1'b1;
        end
      end else begin
        w_wr[i] = 1'b0;
      end
    end
  end

  // State update: reset over flush over normal read/write.
  always_ff @(posedge clk) begin
    if (!reset_) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_cnt   <= '0;
      r_wdrop <= 1'b0;
      r_rerr  <= 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        r_data[j] <= '0;
      end
    end else if (!flush_) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_cnt   <= '0;
      r_wdrop <= 1'b0;
      r_rerr  <= 1'b0;
    end else begin
      r_head  <= r_head + w_nr[AW-1:0];
      r_tail  <= r_tail + w_nw[AW-1:0];
      r_cnt   <= r_cnt - w_nr + w_nw;
      r_wdrop <= w_drop;
      r_rerr  <= w_rerr;
      for (int i = 0; i < WRITE; i++) begin
        if (w_wr[i]) begin
          r_data[w_slot[i]] <= wd[i*DATA +: DATA];
        end
      end
    end
  end

endmodule
